// File: rtl/wb_fifo_responder.sv
// Wishbone classic responder: CTRL/STAT/DATA/THR registers around a small FIFO, with wait states and a level irq.
// Define WB_RESP_ERR_EN to add err_o, which terminates push-when-full and pop-when-empty instead of ack_o.
module wb_fifo_responder #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o
`ifdef WB_RESP_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  ctrl_en;
    logic                  ctrl_irq_en;
    logic [3:0]            thr;
    logic                  ovf;
    logic                  udf;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                  req;
    logic                  fire;
    logic                  term_err;
    logic                  is_ctrl, is_stat, is_data, is_thr;
    logic                  full, empty;
    logic                  do_push, do_pop, set_ovf, set_udf;
    logic [3:0]            count4;
    logic                  irq_cond;
    logic [DATA_WIDTH-1:0] rd_data;

    assign req     = cyc_i & stb_i;
    // The terminating edge: immediately from IDLE when there are no wait states, else after the last wait edge.
    assign fire    = req & (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                            ((state == S_WAIT) && (wait_cnt == LAST_WAIT)));

    assign is_ctrl = (adr_i[1:0] == 2'd0);
    assign is_stat = (adr_i[1:0] == 2'd1);
    assign is_data = (adr_i[1:0] == 2'd2);
    assign is_thr  = (adr_i[1:0] == 2'd3);

    assign count4  = 4'(count);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);

    assign do_push = fire &  we_i & is_data & ctrl_en & ~full;
    assign do_pop  = fire & ~we_i & is_data & ctrl_en & ~empty;
    assign set_ovf = fire &  we_i & is_data & ctrl_en &  full;
    assign set_udf = fire & ~we_i & is_data & ctrl_en &  empty;

`ifdef WB_RESP_ERR_EN
    assign term_err = set_ovf | set_udf;
`else
    assign term_err = 1'b0;
`endif

    assign irq_cond = ctrl_irq_en & ctrl_en & (((thr != 4'd0) && (count4 >= thr)) | ovf);

    always_comb begin
        rd_data = '0;
        case (adr_i[1:0])
            2'd0:    rd_data = DATA_WIDTH'({ctrl_en, ctrl_irq_en, 6'b0});
            2'd1:    rd_data = DATA_WIDTH'({full, empty, ovf, udf, count4});
            2'd2:    if (ctrl_en && !empty) rd_data = mem[rd_ptr];
            default: rd_data = DATA_WIDTH'({4'b0, thr});
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ack_o    <= 1'b0;
            dat_o    <= '0;
`ifdef WB_RESP_ERR_EN
            err_o    <= 1'b0;
`endif
        end else begin
            ack_o <= fire & ~term_err;
            dat_o <= (fire & ~term_err & ~we_i) ? rd_data : '0;
`ifdef WB_RESP_ERR_EN
            err_o <= fire & term_err;
`endif
            case (state)
                S_IDLE: begin
                    wait_cnt <= 4'd0;
                    if (req && (WAIT_STATES != 0)) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!req) state <= S_IDLE;
                    else      wait_cnt <= wait_cnt + 4'd1;
                end
                default: state <= S_IDLE;
            endcase
            if (fire) state <= S_ACK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            thr         <= 4'd0;
            ovf         <= 1'b0;
            udf         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            irq_o       <= 1'b0;
        end else begin
            irq_o <= irq_cond;
            if (fire && we_i && is_ctrl) begin
                ctrl_en     <= dat_i[7];
                ctrl_irq_en <= dat_i[6];
            end
            if (fire && we_i && is_thr) thr <= dat_i[3:0];
            if (fire && we_i && is_stat && dat_i[5]) ovf <= 1'b0;
            if (fire && we_i && is_stat && dat_i[4]) udf <= 1'b0;
            if (set_ovf) ovf <= 1'b1;
            if (set_udf) udf <= 1'b1;

            if (fire && we_i && is_ctrl && dat_i[0]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

    // FIFO storage carries data only, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= dat_i;
    end

endmodule

// File: tb/tb_wb_fifo_responder.sv
// Directed bench for wb_fifo_responder (WAIT_STATES=3, FIFO_DEPTH=8); read data checked through an expected-value queue.
module tb_wb_fifo_responder;

    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_w;
    logic [7:0] dat_r;
    logic       ack, irq;
`ifdef WB_RESP_ERR_EN
    wire        err;
`else
    wire        err = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    wb_fifo_responder #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8),
        .WAIT_STATES(WS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cyc_i(cyc),
        .stb_i(stb),
        .we_i (we),
        .adr_i(adr),
        .dat_i(dat_w),
        .dat_o(dat_r),
        .ack_o(ack),
        .irq_o(irq)
`ifdef WB_RESP_ERR_EN
        ,
        .err_o(err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                        output logic [7:0] rdat, output logic [1:0] term, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        lat = 0;
        while (!(ack === 1'b1 || err === 1'b1) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdat = dat_r;
        term = {ack, err};
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("terminated", {31'd0, (ack | err)}, 32'd1);
        @(posedge clk);
        #1;
        check("term_width", {30'd0, ack, err}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        logic [1:0] t;
        int l;
        xfer(1'b1, a, d, r, t, l);
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] e);
        logic [7:0] r;
        logic [1:0] t;
        int l;
        exp_q.push_back(e);
        xfer(1'b0, a, 8'h00, r, t, l);
        check(tag, {24'd0, r}, {24'd0, exp_q.pop_front()});
    endtask

    initial begin
        logic [7:0] r;
        logic [1:0] t;
        int l;
        logic seen;

        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_w = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_dat", {24'd0, dat_r}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        rd("stat_reset", 2'd1, 8'h40);

        xfer(1'b1, 2'd0, 8'h80, r, t, l);
        check("ctrl_wr_latency", l, WS + 1);
        rd("ctrl_rd", 2'd0, 8'h80);

        wr(2'd2, 8'h11);
        wr(2'd2, 8'h22);
        wr(2'd2, 8'h33);
        rd("stat_3", 2'd1, 8'h03);
        rd("pop_11", 2'd2, 8'h11);
        rd("pop_22", 2'd2, 8'h22);
        rd("pop_33", 2'd2, 8'h33);
        rd("pop_empty", 2'd2, 8'h00);
        rd("stat_udf", 2'd1, 8'h50);
        wr(2'd1, 8'h10);
        rd("stat_udf_clr", 2'd1, 8'h40);

        for (int i = 0; i < 9; i++) wr(2'd2, 8'hA0 + 8'(i));
        rd("stat_full_ovf", 2'd1, 8'hA8);
        wr(2'd1, 8'h20);
        rd("stat_ovf_clr", 2'd1, 8'h88);
        rd("pop_first_of_full", 2'd2, 8'hA0);
        wr(2'd0, 8'h81);
        rd("stat_flush", 2'd1, 8'h40);
        rd("ctrl_flush_reads0", 2'd0, 8'h80);

        wr(2'd0, 8'h00);
        wr(2'd2, 8'h55);
        rd("pop_disabled", 2'd2, 8'h00);
        rd("stat_disabled", 2'd1, 8'h40);

        wr(2'd0, 8'hC0);
        wr(2'd3, 8'hF2);
        rd("thr_rd", 2'd3, 8'h02);
        wr(2'd2, 8'h61);
        check("irq_below_thr", {31'd0, irq}, 32'd0);
        wr(2'd2, 8'h62);
        check("irq_at_thr", {31'd0, irq}, 32'd1);
        rd("pop_61", 2'd2, 8'h61);
        check("irq_after_pop", {31'd0, irq}, 32'd0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen = seen | ack | err;
        end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | ack | err;
        end
        check("abort_no_ack", {31'd0, seen}, 32'd0);
        rd("stat_after_abort", 2'd1, 8'h01);
        rd("pop_62", 2'd2, 8'h62);

        xfer(1'b0, 2'd2, 8'h00, r, t, l);
`ifdef WB_RESP_ERR_EN
        check("empty_pop_term", {30'd0, t}, 32'd1);
`else
        check("empty_pop_term", {30'd0, t}, 32'd2);
`endif
        check("empty_pop_dat", {24'd0, r}, 32'd0);
        rd("stat_udf_again", 2'd1, 8'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
